// File: rtl/alu_sat_stage.sv
// alu_sat_stage: registered execute-stage ALU slice with signed saturation,
// a Z/V/N flag register and a stall/flush handshake toward EX/MEM.
// Also contains cla_16bit, the carry-lookahead adder that feeds it.
// Optional feature macro: ALU_PADDSB_EN. When it is defined, op=11 is a packed
// 4x4-bit saturating add. When it is undefined, op=11 is illegal and yields
// 16'h0000 with the flags held.

module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [16:0] carry_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Four 4-bit lookahead groups; each group resolves its carries from its own carry-in.
    always_comb begin
        logic [16:0] c;
        int          bi;
        c    = 17'd0;
        bi   = 0;
        c[0] = cin;
        for (int grp = 0; grp < 4; grp++) begin
            bi = grp * 4;
            c[bi+1] = g_s[bi] | (p_s[bi] & c[bi]);
            c[bi+2] = g_s[bi+1] | (p_s[bi+1] & g_s[bi]) | (p_s[bi+1] & p_s[bi] & c[bi]);
            c[bi+3] = g_s[bi+2] | (p_s[bi+2] & g_s[bi+1]) | (p_s[bi+2] & p_s[bi+1] & g_s[bi])
                    | (p_s[bi+2] & p_s[bi+1] & p_s[bi] & c[bi]);
            c[bi+4] = g_s[bi+3] | (p_s[bi+3] & g_s[bi+2]) | (p_s[bi+3] & p_s[bi+2] & g_s[bi+1])
                    | (p_s[bi+3] & p_s[bi+2] & p_s[bi+1] & g_s[bi])
                    | (p_s[bi+3] & p_s[bi+2] & p_s[bi+1] & p_s[bi] & c[bi]);
        end
        carry_s = c;
    end

    assign sum  = p_s ^ carry_s[15:0];
    assign cout = carry_s[16];
endmodule

module alu_sat_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             stall,
    input  logic             flush,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_XOR    = 2'b10;
    localparam logic [1:0] OP_PADDSB = 2'b11;

`ifdef ALU_PADDSB_EN
    // Four independent signed nibble adds, each clamped to [-8, 7].
    function automatic logic [15:0] paddsb(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        logic [4:0]  s;
        r = 16'h0000;
        for (int ln = 0; ln < 4; ln++) begin
            s = {x[ln*4+3], x[ln*4 +: 4]} + {y[ln*4+3], y[ln*4 +: 4]};
            if (s[4] != s[3]) begin
                r[ln*4 +: 4] = s[4] ? 4'h8 : 4'h7;
            end else begin
                r[ln*4 +: 4] = s[3:0];
            end
        end
        return r;
    endfunction
`endif

    logic [15:0] add_b_s;
    logic        add_cin_s;
    logic [15:0] sum_s;
    logic        adder_cout_unused_s;
    logic        ovf_s;
    logic [15:0] sat_s;
    logic [15:0] res_s;
    logic        upd_z_s;
    logic        upd_vn_s;

    logic        out_valid_r;
    logic [15:0] result_r;
    logic        flag_z_r;
    logic        flag_v_r;
    logic        flag_n_r;

    // Subtraction is a + ~b + 1 through the same adder.
    always_comb begin
        add_b_s   = opb;
        add_cin_s = 1'b0;
        if (op == OP_SUB) begin
            add_b_s   = ~opb;
            add_cin_s = 1'b1;
        end else begin
            add_b_s   = opb;
            add_cin_s = 1'b0;
        end
    end

    cla_16bit u_cla (
        .a    (opa),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (sum_s),
        .cout (adder_cout_unused_s)
    );

    // Signed overflow from operand/sum sign bits; clamp toward the sign of operand A.
    always_comb begin
        ovf_s = (opa[15] == add_b_s[15]) && (sum_s[15] != opa[15]);
        sat_s = sum_s;
        if (ovf_s) begin
            sat_s = opa[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            sat_s = sum_s;
        end
    end

    // Select the result for this op and decide which flags it is allowed to update.
    always_comb begin
        res_s    = 16'h0000;
        upd_z_s  = 1'b0;
        upd_vn_s = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_s    = sat_s;
                upd_z_s  = 1'b1;
                upd_vn_s = 1'b1;
            end
            OP_XOR: begin
                res_s   = opa ^ opb;
                upd_z_s = 1'b1;
            end
            OP_PADDSB: begin
`ifdef ALU_PADDSB_EN
                res_s   = paddsb(opa, opb);
                upd_z_s = 1'b1;
`else
                res_s   = 16'h0000;
`endif
            end
            default: begin
                res_s = 16'h0000;
            end
        endcase
    end

    assign in_ready = !stall;

    // Output and flag register: flush beats stall, stall beats accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= 16'h0000;
            flag_z_r    <= 1'b0;
            flag_v_r    <= 1'b0;
            flag_n_r    <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (stall) begin
            out_valid_r <= out_valid_r;
        end else if (in_valid) begin
            out_valid_r <= 1'b1;
            result_r    <= res_s;
            if (upd_z_s) begin
                flag_z_r <= (res_s == 16'h0000);
            end
            if (upd_vn_s) begin
                flag_v_r <= ovf_s;
                flag_n_r <= res_s[15];
            end
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flag_z    = flag_z_r;
    assign flag_v    = flag_v_r;
    assign flag_n    = flag_n_r;
endmodule

// File: tb/tb_alu_sat_stage.sv
// Testbench for alu_sat_stage: scoreboard of expected results plus a
// behavioural model of the output/flag registers. Honours ALU_PADDSB_EN.

module tb_alu_sat_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        stall;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    logic        m_valid;
    logic [15:0] m_res;
    logic        m_z;
    logic        m_v;
    logic        m_n;

    alu_sat_stage #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .stall     (stall),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .result    (result),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_paddsb(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  na;
        logic [3:0]  nb;
        int          s;
        r = 16'h0000;
        for (int ln = 0; ln < 4; ln++) begin
            na = a[ln*4 +: 4];
            nb = b[ln*4 +: 4];
            s  = int'($signed(na)) + int'($signed(nb));
            if (s > 7) s = 7;
            if (s < -8) s = -8;
            r[ln*4 +: 4] = s[3:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_res   = 16'h0000;
        m_z     = 1'b0;
        m_v     = 1'b0;
        m_n     = 1'b0;
        exp_q.delete();
    endtask

    // Apply one instruction to the model (called only on accept).
    task automatic model_accept(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        int          sa;
        int          sb;
        int          s;
        logic [15:0] r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = 0;
        r  = 16'h0000;
        case (o)
            2'b00, 2'b01: begin
                s = (o == 2'b00) ? sa + sb : sa - sb;
                if (s > 32767) begin
                    r = 16'h7FFF; m_v = 1'b1;
                end else if (s < -32768) begin
                    r = 16'h8000; m_v = 1'b1;
                end else begin
                    r = s[15:0]; m_v = 1'b0;
                end
                m_z = (r == 16'h0000);
                m_n = r[15];
            end
            2'b10: begin
                r   = a ^ b;
                m_z = (r == 16'h0000);
            end
            default: begin
`ifdef ALU_PADDSB_EN
                r   = ref_paddsb(a, b);
                m_z = (r == 16'h0000);
`else
                r   = 16'h0000;
`endif
            end
        endcase
        m_valid = 1'b1;
        m_res   = r;
        exp_q.push_back(r);
    endtask

    // Drive one cycle, advance the model at the edge, then compare.
    task automatic step(input logic iv, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic st, input logic fl);
        logic        acc;
        logic [15:0] e;
        in_valid = iv; op = o; opa = a; opb = b; stall = st; flush = fl;
        #1;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, !st});
        @(posedge clk);
        acc = 1'b0;
        if (fl) begin
            m_valid = 1'b0;
        end else if (st) begin
            acc = 1'b0;
        end else if (iv) begin
            model_accept(o, a, b);
            acc = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (acc) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_result", {16'd0, result}, {16'd0, e});
            end
        end
        check_eq("result", {16'd0, result}, {16'd0, m_res});
        check_eq("flags_zvn", {29'd0, flag_z, flag_v, flag_n}, {29'd0, m_z, m_v, m_n});
    endtask

    initial begin
        // Reset held with a live instruction on the inputs.
        rst = 1'b1; in_valid = 1'b1; op = 2'b00; opa = 16'h0005; opb = 16'h0003;
        stall = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_result", {16'd0, result}, 32'd0);
        check_eq("rst_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
        rst = 1'b0;

        step(1'b1, 2'b00, 16'h0005, 16'h0003, 1'b0, 1'b0);   // 0008
        step(1'b1, 2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0);   // sat 7FFF
        step(1'b1, 2'b00, 16'h8000, 16'hFFFF, 1'b0, 1'b0);   // sat 8000
        step(1'b1, 2'b01, 16'h0005, 16'h0005, 1'b0, 1'b0);   // 0, Z=1
        step(1'b1, 2'b01, 16'h8000, 16'h0001, 1'b0, 1'b0);   // sat 8000
        step(1'b1, 2'b01, 16'h0000, 16'h8000, 1'b0, 1'b0);   // sat 7FFF
        step(1'b1, 2'b10, 16'h00FF, 16'h00FF, 1'b0, 1'b0);   // XOR 0, V held
        step(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);   // idle

        // Stall holds the previous result, then releases.
        step(1'b1, 2'b00, 16'h0001, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 2'b01, 16'h0009, 16'h0004, 1'b1, 1'b0);
        step(1'b1, 2'b01, 16'h0009, 16'h0004, 1'b1, 1'b0);
        step(1'b1, 2'b01, 16'h0009, 16'h0004, 1'b0, 1'b0);

        // Flush wins over stall and accept.
        step(1'b1, 2'b00, 16'h0002, 16'h0002, 1'b1, 1'b1);
        step(1'b1, 2'b00, 16'h0002, 16'h0002, 1'b0, 1'b1);

        // op=11 with and without the packed-add feature.
        step(1'b1, 2'b11, 16'h7070, 16'h1190, 1'b0, 1'b0);
        step(1'b1, 2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0);   // 0, Z=1
        step(1'b1, 2'b11, 16'h8F77, 16'h8F11, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle discards the in-flight result.
        step(1'b1, 2'b00, 16'h1234, 16'h0001, 1'b0, 1'b0);
        in_valid = 1'b1; op = 2'b00; opa = 16'h0100; opb = 16'h0100;
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("async_rst_result", {16'd0, result}, 32'd0);
        check_eq("async_rst_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 2'b00, 16'h0100, 16'h0100, 1'b0, 1'b0);   // first capture after release

        // Randomised mix with corner operands.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 3) == 0) rb = (i % 3 == 0) ? 16'h8000 : 16'h0001;
            if ($urandom_range(0, 5) == 0) rb = ra;
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), ra, rb,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
